// File: rtl/beta_useq.sv
// beta_useq: micro-program sequencer for the beta control unit (fetch, decode hand-off, micro-ROM walk).
// Optional macro BETA_USEQ_PERF_EN adds the instret_o / cycle_o performance counters.
module beta_useq #(
  parameter int XLEN    = 32,
  parameter int USTEP_W = 3,
  parameter int UCTRL_W = 24
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  output logic                 imem_req_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [XLEN-1:0]      imem_rdata_i,
  output logic [XLEN-1:0]      instr_o,
  input  logic [8:0]           cu_addr_i,
  input  logic                 invalid_instr_i,
  output logic [9+USTEP_W-1:0] uaddr_o,
  input  logic [UCTRL_W+1:0]   uword_i,
  output logic [UCTRL_W-1:0]   ctrl_o,
  input  logic                 stall_i,
  output logic                 pc_en_o,
  output logic                 trap_o,
  output logic                 busy_o
`ifdef BETA_USEQ_PERF_EN
  ,
  output logic [63:0]          instret_o,
  output logic [63:0]          cycle_o
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [XLEN-1:0]    r_instr;
  logic [8:0]         r_cu_addr;
  logic [USTEP_W-1:0] r_ustep;

  logic w_uend;
  logic w_uwait;
  logic w_hold;
  logic w_ustep_max;
  logic w_in_exec;
  logic w_retire;
  logic w_overrun;
  logic w_latch_instr;
  logic w_enter_exec;

  // Micro-word flag decode; a WAIT word only holds while the datapath reports busy.
  assign w_uend      = uword_i[UCTRL_W+1];
  assign w_uwait     = uword_i[UCTRL_W];
  assign w_hold      = w_uwait & stall_i;
  assign w_ustep_max = &r_ustep;
  assign w_in_exec   = (r_state == S_EXEC);
  assign w_retire    = w_in_exec & w_uend & ~w_hold;
  assign w_overrun   = w_in_exec & ~w_uend & ~w_hold & w_ustep_max;

  // Data may come back in the grant cycle, so FETCH can latch directly.
  assign w_latch_instr = ((r_state == S_FETCH) & imem_gnt_i & imem_rvalid_i) |
                         ((r_state == S_WAIT_DATA) & imem_rvalid_i);
  assign w_enter_exec  = (r_state == S_DECODE) & ~invalid_instr_i;

  always_comb begin
    // NOTE: default assignment first so every path drives w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_gnt_i) begin
          w_state_nxt = imem_rvalid_i ? S_DECODE : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (imem_rvalid_i) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE:    w_state_nxt = invalid_instr_i ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (w_retire) begin
          w_state_nxt = S_FETCH;
        end else if (w_overrun) begin
          w_state_nxt = S_TRAP;
        end
      end
      S_TRAP:      w_state_nxt = S_FETCH;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_instr <= '0;
    end else if (w_latch_instr) begin
      r_instr <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cu_addr <= '0;
    end else if (w_enter_exec) begin
      r_cu_addr <= cu_addr_i;
    end
  end

  // Step advances only on a non-final, non-held word that still has room to grow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ustep <= '0;
    end else if (w_enter_exec) begin
      r_ustep <= '0;
    end else if (w_in_exec && !w_hold && !w_uend && !w_ustep_max) begin
      r_ustep <= r_ustep + 1'b1;
    end
  end

  assign imem_req_o = (r_state == S_FETCH);
  assign instr_o    = r_instr;
  assign uaddr_o    = {r_cu_addr, r_ustep};
  assign ctrl_o     = w_in_exec ? uword_i[UCTRL_W-1:0] : '0;
  assign pc_en_o    = w_retire;
  assign trap_o     = (r_state == S_TRAP);
  assign busy_o     = (r_state != S_IDLE);

`ifdef BETA_USEQ_PERF_EN
  logic [63:0] r_instret;
  logic [63:0] r_cycle;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_instret <= '0;
      r_cycle   <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign instret_o = r_instret;
  assign cycle_o   = r_cycle;
`endif

endmodule

// File: tb/tb_beta_useq.sv
// Scoreboard bench for beta_useq: stimulus queues bus replies and expected retire/trap events,
// a monitor pops and compares whenever pc_en_o or trap_o fires.
`timescale 1ns/1ps
module tb_beta_useq;
  localparam int XLEN    = 32;
  localparam int USTEP_W = 3;
  localparam int UCTRL_W = 24;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic                 imem_req_o;
  logic                 imem_gnt_i;
  logic                 imem_rvalid_i;
  logic [XLEN-1:0]      imem_rdata_i;
  logic [XLEN-1:0]      instr_o;
  logic [8:0]           cu_addr_i;
  logic                 invalid_instr_i;
  logic [9+USTEP_W-1:0] uaddr_o;
  logic [UCTRL_W+1:0]   uword_i;
  logic [UCTRL_W-1:0]   ctrl_o;
  logic                 stall_i;
  logic                 pc_en_o;
  logic                 trap_o;
  logic                 busy_o;
`ifdef BETA_USEQ_PERF_EN
  logic [63:0]          instret_o;
  logic [63:0]          cycle_o;
`endif

  beta_useq #(.XLEN(XLEN), .USTEP_W(USTEP_W), .UCTRL_W(UCTRL_W)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .imem_req_o      (imem_req_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_o         (instr_o),
    .cu_addr_i       (cu_addr_i),
    .invalid_instr_i (invalid_instr_i),
    .uaddr_o         (uaddr_o),
    .uword_i         (uword_i),
    .ctrl_o          (ctrl_o),
    .stall_i         (stall_i),
    .pc_en_o         (pc_en_o),
    .trap_o          (trap_o),
    .busy_o          (busy_o)
`ifdef BETA_USEQ_PERF_EN
    ,
    .instret_o       (instret_o),
    .cycle_o         (cycle_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          gnt_dly;
    int          rv_dly;
  } bus_t;

  typedef struct {
    bit          is_trap;
    logic [31:0] instr;
    logic [11:0] uaddr;
    logic [23:0] ctrl;
    int          lat;
    int          req_len;
    int          exec_n;
    int          max_hold;
  } exp_t;

  bus_t bus_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decoder model: fixed instruction -> micro-program entry table.
  always_comb begin
    cu_addr_i       = 9'h000;
    invalid_instr_i = 1'b0;
    case (instr_o)
      32'h00500093, 32'h00A00113: cu_addr_i = 9'h020;
      32'h00208133:               cu_addr_i = 9'h030;
      32'h12345678:               cu_addr_i = 9'h040;
      default:                    invalid_instr_i = 1'b1;
    endcase
  end

  // Micro-ROM model: {END, WAIT, ctrl}.
  always_comb begin
    uword_i = '0;
    case (uaddr_o)
      12'h100: uword_i = {2'b10, 24'hA00001};
      12'h180: uword_i = {2'b00, 24'h000011};
      12'h181: uword_i = {2'b01, 24'h000022};
      12'h182: uword_i = {2'b10, 24'h000033};
      12'h200, 12'h201, 12'h202, 12'h203,
      12'h204, 12'h205, 12'h206, 12'h207:
        uword_i = {2'b00, 21'h000008, uaddr_o[2:0]};
      default: uword_i = '0;
    endcase
  end

  // Datapath stall model: 5 busy cycles on the WAIT word, and busy on the WAIT=0 ADDI word.
  initial begin : stall_model
    int left;
    left    = 5;
    stall_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (ctrl_o == 24'h000022) begin
        stall_i = (left > 0);
        if (left > 0) left--;
      end else begin
        left    = 5;
        stall_i = (ctrl_o == 24'hA00001);
      end
    end
  end

  // Instruction bus model driven from bus_q.
  initial begin : bus_model
    bus_t cur;
    int   req_cnt;
    int   rv_cnt;
    bit   rv_pend;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEADBEEF;
    req_cnt       = 0;
    rv_cnt        = 0;
    rv_pend       = 1'b0;
    cur           = '{32'h0, 0, 0};
    forever begin
      @(posedge clk_i);
      #1;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEADBEEF;
      if (!rstn_i) begin
        req_cnt = 0;
        rv_pend = 1'b0;
      end else if (rv_pend) begin
        if (rv_cnt == cur.rv_dly) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = cur.data;
          rv_pend       = 1'b0;
        end else begin
          rv_cnt++;
        end
      end else if (imem_req_o && bus_q.size() > 0) begin
        if (req_cnt == bus_q[0].gnt_dly) begin
          cur        = bus_q.pop_front();
          imem_gnt_i = 1'b1;
          req_cnt    = 0;
          if (cur.rv_dly == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = cur.data;
          end else begin
            rv_pend = 1'b1;
            rv_cnt  = 1;
          end
        end else begin
          req_cnt++;
        end
      end
    end
  end

  // Monitor: tracks per-instruction timing from FETCH entry, compares on every retire/trap.
  initial begin : monitor
    logic        prev_req, prev_rv, prev_exec;
    logic [31:0] prev_instr;
    logic [11:0] prev_uaddr;
    logic [23:0] prev_ctrl;
    int          lat, req_len, exec_n, hold, max_hold;
    bit          unstable;
    exp_t        e;
    prev_req = 0; prev_rv = 0; prev_exec = 0;
    prev_instr = '0; prev_uaddr = '0; prev_ctrl = '0;
    lat = 0; req_len = 0; exec_n = 0; hold = 0; max_hold = 0; unstable = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        prev_req = 0; prev_rv = 0; prev_exec = 0;
        prev_instr = '0; prev_uaddr = '0; prev_ctrl = '0;
      end else begin
        if (imem_req_o && !prev_req) begin
          lat = 0; req_len = 0; exec_n = 0; hold = 0; max_hold = 0; unstable = 0;
        end
        lat++;
        if (imem_req_o) req_len++;
        if (ctrl_o != '0) begin
          exec_n++;
          if (prev_exec && uaddr_o == prev_uaddr) begin
            hold++;
            if (ctrl_o != prev_ctrl) unstable = 1;
          end else begin
            hold = 1;
          end
          if (hold > max_hold) max_hold = hold;
        end
        if (instr_o != prev_instr) check("instr_latched_on_rvalid", prev_rv, 1);
        if (pc_en_o || trap_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", {pc_en_o, trap_o}, 0);
          end else begin
            e = exp_q.pop_front();
            check("retire_kind", {pc_en_o, trap_o}, {~e.is_trap, e.is_trap});
            check("instr", instr_o, e.instr);
            check("latency", lat, e.lat);
            check("req_len", req_len, e.req_len);
            check("exec_cycles", exec_n, e.exec_n);
            check("max_hold", max_hold, e.max_hold);
            check("ctrl_stable", unstable, 0);
            if (!e.is_trap) begin
              check("uaddr", uaddr_o, e.uaddr);
              check("ctrl", ctrl_o, e.ctrl);
            end else begin
              check("trap_ctrl_zero", ctrl_o, 0);
            end
          end
        end
        prev_req   = imem_req_o;
        prev_rv    = imem_rvalid_i;
        prev_exec  = (ctrl_o != '0);
        prev_instr = instr_o;
        prev_uaddr = uaddr_o;
        prev_ctrl  = ctrl_o;
      end
    end
  end

  task automatic push_bus(input logic [31:0] data, input int gnt_dly, input int rv_dly);
    bus_t b;
    b = '{data, gnt_dly, rv_dly};
    bus_q.push_back(b);
  endtask

  task automatic issue(input logic [31:0] data, input int gnt_dly, input int rv_dly,
                       input bit is_trap, input logic [11:0] uaddr, input logic [23:0] ctrl,
                       input int lat, input int req_len, input int exec_n, input int max_hold);
    exp_t e;
    push_bus(data, gnt_dly, rv_dly);
    e = '{is_trap, data, uaddr, ctrl, lat, req_len, exec_n, max_hold};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_i);
    end
    check("drain_timeout_pending", exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   imem_req_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_ctrl"},  ctrl_o, 0);
    check({tag, "_pc_en"}, pc_en_o, 0);
    check({tag, "_trap"},  trap_o, 0);
    check({tag, "_instr"}, instr_o, 0);
    check({tag, "_uaddr"}, uaddr_o, 0);
`ifdef BETA_USEQ_PERF_EN
    check({tag, "_instret"}, instret_o, 0);
    check({tag, "_cycle"},   cycle_o, 0);
`endif
  endtask

  initial begin : stimulus
    rstn_i = 1'b0;
    //     instr         gnt rv trap uaddr    ctrl       lat req exec hold
    issue(32'h00500093, 0, 1, 0, 12'h100, 24'hA00001,  4, 1, 1, 1);
    issue(32'h00A00113, 3, 2, 0, 12'h100, 24'hA00001,  8, 4, 1, 1);
    issue(32'h00208133, 0, 1, 0, 12'h182, 24'h000033, 11, 1, 8, 6);
    issue(32'h00000000, 0, 1, 1, 12'h000, 24'h000000,  4, 1, 0, 0);
    issue(32'h12345678, 0, 1, 1, 12'h000, 24'h000000, 12, 1, 8, 1);
    issue(32'h00500093, 1, 0, 0, 12'h100, 24'hA00001,  4, 2, 1, 1);
    repeat (2) @(negedge clk_i);
    check_idle("reset");

    rstn_i = 1'b1;
    #1;
    check("idle_before_first_clock_req", imem_req_o, 0);
    @(posedge clk_i);
    #1;
    check("fetch_after_first_clock_req", imem_req_o, 1);
    wait_drain(300);
`ifdef BETA_USEQ_PERF_EN
    check("instret_after_batch", instret_o, 4);
`endif

    // Overrun program, reset asynchronously while executing step 2.
    push_bus(32'h12345678, 0, 1);
    for (int i = 0; i < 60; i++) begin
      if (uaddr_o == 12'h202 && ctrl_o != '0) break;
      @(negedge clk_i);
    end
    check("reach_exec_step2", uaddr_o, 12'h202);
    #2;
    rstn_i = 1'b0;
    #1;
    check_idle("async_reset");
    repeat (2) @(negedge clk_i);
    issue(32'h00500093, 0, 1, 0, 12'h100, 24'hA00001, 4, 1, 1, 1);
    rstn_i = 1'b1;
    #1;
    check("idle_after_release_req", imem_req_o, 0);
    @(posedge clk_i);
    #1;
    check("fetch_resumes_req", imem_req_o, 1);
`ifdef BETA_USEQ_PERF_EN
    check("cycle_after_release", cycle_o, 1);
`endif
    wait_drain(100);
`ifdef BETA_USEQ_PERF_EN
    check("instret_after_reset", instret_o, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
